// File: rtl/weight_stream_pkg.sv
// Shared types and helpers for the weight ROM prefetch streamer.
package weight_stream_pkg;

  typedef struct packed {
    logic valid;
    logic last;
  } token_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int addr_width_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/weight_stream_fwft_fifo.sv
// First-word-fall-through FIFO with synchronous flush and occupancy count.
module weight_stream_fwft_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_s, do_push_s, do_pop_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  assign full_s    = (cnt_q == CW'(DEPTH));
  assign do_pop_s  = pop_i && (cnt_q != {CW{1'b0}});
  // A pop frees the slot, so a push at full is legal only alongside it.
  assign do_push_s = push_i && (!full_s || do_pop_s);
  assign data_o    = mem_q[rd_ptr_q];
  assign valid_o   = (cnt_q != {CW{1'b0}});
  assign count_o   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      cnt_d    = {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_d = ptr_inc(wr_ptr_q);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = ptr_inc(rd_ptr_q);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  weight_stream_fifo_chk u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_i),
    .pop_i  (do_pop_s),
    .full_i (full_s)
  );

endmodule

module weight_stream_fifo_chk (
  input logic clk,
  input logic rst_n,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(push_i && full_i && !pop_i));
endmodule

// File: rtl/weight_rom_prefetch_streamer.sv
// Fixed-latency ROM reader turned into a lossless valid/ready weight stream.
// Optional WEIGHT_STREAM_PERF_EN adds stall/starve cycle counters.
module weight_rom_prefetch_streamer
  import weight_stream_pkg::*;
#(
  parameter int WEIGHT_PRECISION_0 = 16,
  parameter int WEIGHT_PARALLELISM = 1,
  parameter int OUT_DEPTH          = 32,
  parameter int ROM_LATENCY        = 2,
  parameter int FIFO_DEPTH         = 4,
  parameter int ADDR_WIDTH         = addr_width_f(OUT_DEPTH)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         enable,
  input  logic                                         restart,
  output logic [ADDR_WIDTH-1:0]                        rom_addr,
  output logic                                         rom_ce,
  input  logic [WEIGHT_PRECISION_0*WEIGHT_PARALLELISM-1:0] rom_q,
  output logic [WEIGHT_PRECISION_0-1:0]                data_out [WEIGHT_PARALLELISM],
  output logic                                         data_out_valid,
  input  logic                                         data_out_ready,
`ifdef WEIGHT_STREAM_PERF_EN
  output logic [31:0]                                  stall_cycles,
  output logic [31:0]                                  starve_cycles,
`endif
  output logic                                         pass_done
);
  localparam int DW  = WEIGHT_PRECISION_0 * WEIGHT_PARALLELISM;
  localparam int FW  = DW + 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);

  if (FIFO_DEPTH < ROM_LATENCY + 2) begin : g_depth_check
    $error("FIFO_DEPTH must be at least ROM_LATENCY+2");
  end

  state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  token_t          tok_q [ROM_LATENCY];
  token_t          tok_d;
  logic [CW-1:0]   inflight_s, credit_s;
  logic [FCW-1:0]  fifo_cnt_s;
  logic [FW-1:0]   head_s;
  logic            issue_s, last_s, hs_s, push_s, pass_done_q;

  assign rom_ce   = 1'b1;
  assign rom_addr = addr_q;
  assign last_s   = (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1));
  assign hs_s     = data_out_valid && data_out_ready;
  assign push_s   = tok_q[ROM_LATENCY-1].valid;
  assign pass_done = pass_done_q;

  always_comb begin
    inflight_s = {CW{1'b0}};
    for (int i = 0; i < ROM_LATENCY; i++) inflight_s = inflight_s + CW'(tok_q[i].valid);
  end

  // Credit counts both in-flight reads and buffered beats; same-cycle pops are ignored.
  assign credit_s = CW'(fifo_cnt_s) + inflight_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = enable ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = RUN; else state_d = IDLE;
        RUN:     if (!enable) state_d = DRAIN; else state_d = RUN;
        DRAIN: begin
          if (enable)                         state_d = RUN;
          else if (inflight_s == {CW{1'b0}})  state_d = IDLE;
          else                                state_d = DRAIN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    issue_s = 1'b0;
    if ((state_q == RUN) && !restart) issue_s = (credit_s < CW'(FIFO_DEPTH));
    else                              issue_s = 1'b0;
  end

  always_comb begin
    addr_d = addr_q;
    if (restart)                addr_d = {ADDR_WIDTH{1'b0}};
    else if (issue_s && last_s) addr_d = {ADDR_WIDTH{1'b0}};
    else if (issue_s)           addr_d = addr_q + ADDR_WIDTH'(1);
    else                        addr_d = addr_q;
    tok_d.valid = issue_s;
    tok_d.last  = issue_s && last_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= {ADDR_WIDTH{1'b0}};
      pass_done_q <= 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) tok_q[i] <= '0;
    end else if (restart) begin
      addr_q      <= addr_d;
      pass_done_q <= 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) tok_q[i] <= '0;
    end else begin
      addr_q      <= addr_d;
      pass_done_q <= hs_s && head_s[0];
      tok_q[0]    <= tok_d;
      for (int i = 1; i < ROM_LATENCY; i++) tok_q[i] <= tok_q[i-1];
    end
  end

  weight_stream_fwft_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush_i (restart),
    .push_i  (push_s),
    .data_i  ({rom_q, tok_q[ROM_LATENCY-1].last}),
    .pop_i   (hs_s),
    .data_o  (head_s),
    .valid_o (data_out_valid),
    .count_o (fifo_cnt_s)
  );

  always_comb begin
    for (int j = 0; j < WEIGHT_PARALLELISM; j++)
      data_out[j] = head_s[1 + j*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0];
  end

`ifdef WEIGHT_STREAM_PERF_EN
  logic [31:0] stall_q, starve_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= 32'd0;
      starve_q <= 32'd0;
    end else if (restart) begin
      stall_q  <= 32'd0;
      starve_q <= 32'd0;
    end else begin
      if (data_out_valid && !data_out_ready) stall_q <= sat_inc32(stall_q);
      if ((state_q == RUN) && !data_out_valid) starve_q <= sat_inc32(starve_q);
    end
  end

  assign stall_cycles  = stall_q;
  assign starve_cycles = starve_q;
`endif

endmodule

// File: tb/tb_weight_rom_prefetch_streamer.sv
// Directed + randomized bench for weight_rom_prefetch_streamer with an in-order beat model.
module tb_weight_rom_prefetch_streamer;
  localparam int P   = 16;
  localparam int PAR = 1;
  localparam int OD  = 32;
  localparam int LAT = 2;
  localparam int FD  = 4;
  localparam int AW  = 6;

  logic clk = 1'b0;
  logic rst, enable, restart, ready;
  logic [AW-1:0]    rom_addr;
  logic             rom_ce;
  logic [P*PAR-1:0] rom_q;
  logic [P-1:0]     data_out [PAR];
  logic             data_out_valid, pass_done;
`ifdef WEIGHT_STREAM_PERF_EN
  logic [31:0] stall_cycles, starve_cycles;
`endif

  always #5 clk = ~clk;

  // ROM model: data equals address, LAT cycles after the address is presented.
  logic [AW-1:0] rp [LAT];
  always @(posedge clk) begin
    rp[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign rom_q = P'(rp[LAT-1]);

  weight_rom_prefetch_streamer dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .restart        (restart),
    .rom_addr       (rom_addr),
    .rom_ce         (rom_ce),
    .rom_q          (rom_q),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (ready),
`ifdef WEIGHT_STREAM_PERF_EN
    .stall_cycles   (stall_cycles),
    .starve_cycles  (starve_cycles),
`endif
    .pass_done      (pass_done)
  );

  int checks, failures;
  int exp_beat, issued, popped, hs_count, pd_cnt, cyc;
  logic pd_exp, skip_addr, cur_valid;
  logic [AW-1:0] prev_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    exp_beat  = 0;
    pd_exp    = 1'b0;
    issued    = 0;
    popped    = 0;
    skip_addr = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},  32'(data_out_valid), 32'd0);
    chk({tag, "_pdone"},  32'(pass_done),      32'd0);
    chk({tag, "_data"},   32'(data_out[0]),    32'd0);
    chk({tag, "_addr"},   32'(rom_addr),       32'd0);
    chk({tag, "_ce"},     32'(rom_ce),         32'd1);
  endtask

  // One clock cycle: sample on the falling edge, update the model, step past the rising edge.
  task automatic tick();
    logic hs;
    @(negedge clk);
    chk("pass_done", 32'(pass_done), 32'(pd_exp));
    if (pass_done) pd_cnt++;
    if (skip_addr) skip_addr = 1'b0;
    else if (rom_addr !== prev_addr) issued++;
    prev_addr = rom_addr;
    chk("credit_bound", (issued - popped > FD) ? 32'd1 : 32'd0, 32'd0);
    hs = data_out_valid && ready;
    pd_exp = 1'b0;
    if (hs) begin
      chk("beat", 32'(data_out[0]), 32'(exp_beat));
      if (exp_beat == OD - 1 && !restart) pd_exp = 1'b1;
      exp_beat = (exp_beat + 1) % OD;
      popped++;
      hs_count++;
    end
    cur_valid = data_out_valid;
    if (restart) begin
      exp_beat  = 0;
      issued    = 0;
      popped    = 0;
      skip_addr = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_valid, gaps, w;
    logic [AW-1:0] held;
    checks = 0; failures = 0; hs_count = 0; pd_cnt = 0; cyc = 0;
    rst = 1'b0; enable = 1'b0; restart = 1'b0; ready = 1'b0;
    reset_model();
    prev_addr = '0;
    cur_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // Full-rate pass: first beat at cycle 4, no gaps, wrap and pass_done.
    enable = 1'b1; ready = 1'b1; cyc = 0; first_valid = -1; gaps = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (cur_valid && first_valid < 0) first_valid = cyc - 1;
      if (first_valid >= 0 && (cyc - 1) <= first_valid + 32 && !cur_valid) gaps++;
    end
    chk("first_valid_cycle", 32'(first_valid), 32'd4);
    chk("full_rate_gaps", 32'(gaps), 32'd0);
    chk("wrap_reached", (hs_count >= 33) ? 32'd1 : 32'd0, 32'd1);
    chk("pass_done_count", 32'(pd_cnt), 32'd1);

    // Restart mid-stream, then 3 passes under 30% random ready.
    restart = 1'b1; ready = 1'b0;
    tick();
    restart = 1'b0;
    chk("restart_valid_low", 32'(data_out_valid), 32'd0);
    hs_count = 0; pd_cnt = 0;
    for (int i = 0; i < 3000 && hs_count < 96; i++) begin
      ready = ($urandom_range(0, 99) < 30);
      tick();
    end
    chk("three_passes_beats", 32'(hs_count), 32'd96);

    // Long stall from the first valid beat.
    restart = 1'b1; ready = 1'b0;
    tick();
    restart = 1'b0;
    for (w = 0; w < 20 && !data_out_valid; w++) tick();
    chk("restart_to_valid", 32'(w), 32'd3);
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", 32'(data_out_valid), 32'd1);
      chk("stall_head", 32'(data_out[0]), 32'd0);
      tick();
    end
    chk("stall_addr", 32'(rom_addr), 32'(FD));
`ifdef WEIGHT_STREAM_PERF_EN
    chk("stall_cycles", stall_cycles, 32'd20);
    chk("starve_cycles", starve_cycles, 32'd3);
`endif
    ready = 1'b1; hs_count = 0;
    for (int i = 0; i < 5; i++) begin
      chk("release_b2b", 32'(data_out_valid), 32'd1);
      tick();
    end
    chk("release_beats", 32'(hs_count), 32'd5);

    // Drop enable at address 10, drain, then resume.
    for (w = 0; w < 100 && rom_addr != AW'(10); w++) tick();
    chk("reach_addr10", 32'(rom_addr), 32'd10);
    enable = 1'b0;
    repeat (15) tick();
    chk("drained_valid", 32'(data_out_valid), 32'd0);
    held = rom_addr;
    repeat (3) tick();
    chk("idle_addr_held", 32'(rom_addr), 32'(held));
    chk("resume_point", 32'(rom_addr), 32'(exp_beat));
    enable = 1'b1; hs_count = 0;
    repeat (12) tick();
    chk("resumed_beats", (hs_count >= 5) ? 32'd1 : 32'd0, 32'd1);

    // Restart with data buffered and in flight, enable low: back to IDLE at 0.
    ready = 1'b0;
    repeat (3) tick();
    restart = 1'b1; enable = 1'b0;
    tick();
    restart = 1'b0;
    chk("restart_idle_valid", 32'(data_out_valid), 32'd0);
    chk("restart_idle_addr", 32'(rom_addr), 32'd0);
    repeat (5) tick();
    chk("idle_no_issue_valid", 32'(data_out_valid), 32'd0);
    chk("idle_no_issue_addr", 32'(rom_addr), 32'd0);
    enable = 1'b1; ready = 1'b1; hs_count = 0;
    repeat (10) tick();
    chk("after_restart_beats", (hs_count >= 4) ? 32'd1 : 32'd0, 32'd1);

    // Asynchronous reset mid-stream, then a clean pass.
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    reset_model();
    enable = 1'b1; ready = 1'b1; hs_count = 0; pd_cnt = 0;
    repeat (45) tick();
    chk("post_reset_beats", 32'(hs_count), 32'd41);
    chk("post_reset_pass_done", 32'(pd_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_rom_prefetch_streamer.md
Name: weight_rom_prefetch_streamer

Overview:
- Sits between a parameter ROM wrapper (fixed read latency, ce/address/q interface) and the dense-layer weight input.
- Turns the ROM's open-loop read pipeline into a lossless valid/ready stream.
- Issues addresses ahead under a credit limit, tracks in-flight reads, and lands returning words in a small first-word-fall-through FIFO.
- Backpressure from the consumer therefore never drops or duplicates a weight beat.

Parameters:
- WEIGHT_PRECISION_0, 16, bits per weight element.
- WEIGHT_PARALLELISM, 1, elements per beat.
- OUT_DEPTH, 32, beats per pass; addresses run 0..OUT_DEPTH-1.
- ROM_LATENCY, 2, cycles from address issue to valid rom_q.
- FIFO_DEPTH, 4, output buffer entries. Must be at least ROM_LATENCY+2 for full rate; an elaboration-time assertion enforces this.
- ADDR_WIDTH, $clog2(OUT_DEPTH)+1, ROM address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  level; permits issuing ROM reads.
- restart  in  1  one-cycle synchronous pulse; flush and rewind to address 0.
- rom_addr  out  ADDR_WIDTH  ROM address.
- rom_ce  out  1  ROM clock enable; constant 1 so latency is fixed.
- rom_q  in  WEIGHT_PRECISION_0*WEIGHT_PARALLELISM  ROM read data.
- data_out  out  [WEIGHT_PRECISION_0-1:0] x WEIGHT_PARALLELISM  unpacked weight beat; element j = rom_q slice [j*P+P-1 : j*P].
- data_out_valid  out  1  beat available.
- data_out_ready  in  1  consumer accepts.
- pass_done  out  1  one-cycle pulse when beat OUT_DEPTH-1 handshakes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rom_addr=0, in-flight tracker cleared, FIFO empty.
  - data_out_valid=0, pass_done=0, data_out=0, rom_ce=1.
- FSM states and transitions:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> IDLE when in-flight=0.
  - DRAIN -> RUN when enable=1 again.
- Issue rule, evaluated in RUN only: issue when inflight_cnt + fifo_cnt < FIFO_DEPTH.
  - Pops in the same cycle earn no credit, which keeps the rule conservative.
  - Issue means: rom_addr holds the current address this cycle, a valid token (with last = address==OUT_DEPTH-1) enters a ROM_LATENCY-deep shift register, and the address increments next cycle.
  - Wrap: after OUT_DEPTH-1 the address returns to 0.
  - rom_addr holds its value when not issuing.
- Return path: when the token exits the shift register in cycle t+ROM_LATENCY, {rom_q, last} is written to the FIFO at that clock edge.
  - data_out_valid rises in cycle t+ROM_LATENCY+1.
  - Enable-to-first-valid latency is ROM_LATENCY+2 cycles (one cycle for IDLE->RUN).
- FIFO behaviour:
  - First-word fall-through; data_out is driven from the head entry.
  - Stable while valid && !ready.
  - Push and pop in the same cycle keeps the count unchanged, including at count=FIFO_DEPTH (pop frees the slot) and count=0 (no push-through bypass; pop is not possible).
  - Push while full cannot occur by construction; a simulation assertion covers it.
- pass_done = registered (valid && ready && head.last).
  - Asserted the cycle after the final beat is accepted.
- restart=1 (synchronous, any state):
  - Clears FIFO, token shift register and in-flight count.
  - rom_addr=0.
  - Next state is RUN if enable=1, else IDLE.
  - data_out_valid=0 next cycle; ROM data already in flight is discarded.
  - If restart coincides with a handshake, that beat counts as consumed, but pass_done is suppressed.
- Throughput: with ready held high, one beat per cycle sustained.

Optional Feature:
- Macro: WEIGHT_STREAM_PERF_EN.
- Defined:
  - Adds output stall_cycles[31:0], counting cycles with data_out_valid && !data_out_ready.
  - Adds output starve_cycles[31:0], counting cycles in RUN with data_out_valid=0.
  - Both saturate at all-ones.
  - Both are cleared by rst and by restart.
- Undefined: neither port nor counter exists; remaining behaviour is identical.

Decomposition:
- Package weight_stream_pkg:
  - Token struct {logic valid; logic last;}.
  - FSM enum {IDLE, RUN, DRAIN}.
  - Function for ADDR_WIDTH derivation.
- One sub-module: weight_stream_fwft_fifo, parameterised by width and depth, with count output.
- Top level holds the FSM, address counter, token shift register and unpacking.

Test Plan:
- Ready held 1, enable at cycle 0, ROM model with latency 2 returning data=address.
  - First valid at cycle 4.
  - Beats 0..31 in order, one per cycle.
  - pass_done pulse after beat 31.
  - Beat 32 carries data 0 (wrap).
- Random ready at 30% duty over 3 passes: output sequence exactly 0..31 repeated, no gaps or duplicates; inflight+fifo never exceeds 4.
- Ready low for 20 cycles after the first valid:
  - rom_addr stops at 4; FIFO holds 0..3.
  - data_out stays 0 throughout.
  - On release, beats 0,1,2,3,4 arrive back-to-back.
- Enable dropped mid-pass at address 10:
  - Beats up to 9 (or the issued ones) still delivered; DRAIN -> IDLE.
  - On re-enable, the stream resumes at 10.
- restart pulsed while the FIFO holds 3 entries and 2 reads are in flight:
  - data_out_valid low the next cycle; the next delivered beat is 0; no stale data.
- Async reset asserted mid-stream:
  - All outputs return to reset values immediately.
  - After release plus enable, a clean pass starts from 0.
  - With WEIGHT_STREAM_PERF_EN defined, stall_cycles reads 20 after the stall scenario.
